// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, ROM read issue, 2-entry {pc, word} buffer, valid/ready to decode.
// Optional IFU_ALIGN_CHECK_EN adds misalign_err and rejects misaligned redirects with a sticky stall.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        instruction,
  output logic [31:0]        inst_pc
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic               misalign_err
`endif
);

  // state  | meaning
  // S_BOOT | one idle cycle after reset release, no fetch
  // S_RUN  | normal fetch
  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_word [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;

  logic        pop, push, redirect_take, stall;
  logic [2:0]  occ_next;

`ifdef IFU_ALIGN_CHECK_EN
  assign redirect_take = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign stall         = misalign_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      misalign_err <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign redirect_take = redirect_valid;
  assign stall         = 1'b0;
`endif

  assign inst_valid  = (count != 2'd0);
  assign instruction = fifo_word[rd_ptr];
  assign inst_pc     = fifo_pc[rd_ptr];
  assign imem_addr   = pc_q[IMEM_AW+1:2];

  assign pop  = inst_valid && inst_ready;
  // A response arriving in a redirect cycle belongs to the old stream.
  assign push = inflight_q && !redirect_take;

  // pop implies count >= 1, so this never underflows.
  assign occ_next = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    imem_en = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN:  imem_en = !redirect_valid && !stall && (occ_next < 3'd2);
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= imem_en;
      if (imem_en) begin
        inflight_pc_q <= pc_q;
      end
      if (redirect_take) begin
        pc_q <= redirect_pc;
      end else if (imem_en) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= 32'd0;
        fifo_word[i] <= 32'd0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_take) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= inflight_pc_q;
        fifo_word[wr_ptr] <= imem_rdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
